// File: rtl/max_pool_2x2_pkg.sv
// Shared definitions for the 2x2 max-pooling stage.
// Contents:
//   WRITE_ENB / WRITE_DIS : SRAM write-request encodings
//   PARM_ROW / PARM_CH    : parameter SRAM word offsets
//   pool_state_t          : pooling FSM states
//   ADDR_W                : SRAM address width (address math is done at this width)
package max_pool_2x2_pkg;

    localparam logic WRITE_ENB = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

    localparam int PARM_ROW = 0;
    localparam int PARM_CH  = 1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LD_PARM,
        RD,
        WR,
        FIN
    } pool_state_t;

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM interface shared by the accelerator blocks.
// Signals:
//   cs     : chip select
//   oe     : output enable
//   W_req  : write request (WRITE_ENB / WRITE_DIS)
//   addr   : word address, registered inside the SRAM
//   W_data : write data
//   R_data : read data, valid the cycle after cs/addr are presented
interface sp_ram_intf;

    logic        cs;
    logic        oe;
    logic        W_req;
    logic [31:0] addr;
    logic [31:0] W_data;
    logic [31:0] R_data;

    modport compute (output cs, oe, W_req, addr, W_data, input R_data);
    modport memory  (input cs, oe, W_req, addr, W_data, output R_data);

endinterface

// File: rtl/pool_addr_gen.sv
// Window / output address generator for the 2x2 max-pooling stage.
// Walks ox (innermost), oy, c over the pooled map and tracks the
// input window base address and the sequential output address.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   clr           : restart all counters at 0
//   adv           : step to the next window (issued once per write)
//   num_row       : input height/width R
//   num_ch        : channel count
//   rd_sel        : which of the four window reads (0:+0 1:+1 2:+R 3:+R+1)
//   rd_addr       : input SRAM address for the selected read
//   wr_addr       : pooled SRAM address for the current window
//   last_window   : current window is the last window of the last channel
module pool_addr_gen
    import max_pool_2x2_pkg::*;
#(
    parameter int ROW_W = 6,
    parameter int CH_W  = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              adv,
    input  logic [ROW_W-1:0]  num_row,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [1:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_window
);

    logic [ROW_W-1:0]  pool_p;
    logic [ROW_W-1:0]  p_last;
    logic [CH_W-1:0]   ch_last;
    logic [ADDR_W-1:0] row32;
    logic [ADDR_W-1:0] plane;
    logic [ADDR_W-1:0] row2;
    logic [ADDR_W-1:0] offset;

    logic [ROW_W-1:0]  ox;
    logic [ROW_W-1:0]  oy;
    logic [CH_W-1:0]   c;
    logic [ADDR_W-1:0] ch_base;   // c*R*R
    logic [ADDR_W-1:0] row_base;  // c*R*R + 2*oy*R
    logic [ADDR_W-1:0] base;      // row_base + 2*ox
    logic [ADDR_W-1:0] out_addr;

    // Odd R drops the last row/column simply because P floors and the
    // walk never goes past window P-1 in either direction.
    assign pool_p  = num_row >> 1;
    assign p_last  = pool_p - ROW_W'(1);
    assign ch_last = num_ch - CH_W'(1);
    assign row32   = ADDR_W'(num_row);
    assign plane   = row32 * row32;
    assign row2    = row32 << 1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ox       <= '0;
            oy       <= '0;
            c        <= '0;
            ch_base  <= '0;
            row_base <= '0;
            base     <= '0;
            out_addr <= '0;
        end else if (clr) begin
            ox       <= '0;
            oy       <= '0;
            c        <= '0;
            ch_base  <= '0;
            row_base <= '0;
            base     <= '0;
            out_addr <= '0;
        end else if (adv) begin
            out_addr <= out_addr + ADDR_W'(1);
            if (ox == p_last) begin
                ox <= '0;
                if (oy == p_last) begin
                    // next channel: all bases jump to the next plane
                    oy       <= '0;
                    c        <= c + CH_W'(1);
                    ch_base  <= ch_base + plane;
                    row_base <= ch_base + plane;
                    base     <= ch_base + plane;
                end else begin
                    // next window row is two input rows down
                    oy       <= oy + ROW_W'(1);
                    row_base <= row_base + row2;
                    base     <= row_base + row2;
                end
            end else begin
                ox   <= ox + ROW_W'(1);
                base <= base + ADDR_W'(2);
            end
        end
    end

    always_comb begin
        offset = '0;
        case (rd_sel)
            2'd0:    offset = '0;
            2'd1:    offset = ADDR_W'(1);
            2'd2:    offset = row32;
            default: offset = row32 + ADDR_W'(1);
        endcase
    end

    assign rd_addr     = base + offset;
    assign wr_addr     = out_addr;
    assign last_window = (ox == p_last) && (oy == p_last) && (c == ch_last);

endmodule

// File: rtl/max_pool_2x2.sv
// Stride-2 2x2 max-pooling stage over a CHW feature map.
// After start, reads R and num_CH from the parameter SRAM, then for every
// 2x2 window reads four signed 8-bit activations, keeps the signed max,
// and writes it sign-extended to 16 bits into the pooled SRAM.
// Ports:
//   clk, rstn    : clock, async active-low reset
//   start        : one-cycle start pulse, only honoured in IDLE
//   finish       : one-cycle done pulse
//   param_intf   : parameter SRAM (word 0 = num_row, word 1 = num_CH)
//   input_intf   : conv output SRAM, read only
//   output_intf  : pooled SRAM, write only
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int ROW_W = 6,
    parameter int CH_W  = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          finish,
    sp_ram_intf.compute   param_intf,
    sp_ram_intf.compute   input_intf,
    sp_ram_intf.compute   output_intf
);

    pool_state_t       state;
    pool_state_t       next_state;
    logic [2:0]        cnt;
    logic [ROW_W-1:0]  num_row;
    logic [CH_W-1:0]   num_ch;
    logic [7:0]        max_q;
    logic [7:0]        sample;
    logic [ROW_W-1:0]  pool_p;
    logic              clr;
    logic              adv;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              last_window;
    logic              unused_rdata;

    assign sample = input_intf.R_data[7:0];
    assign pool_p = num_row >> 1;

    // ---------------------------------------------------------------
    // State register, phase counter, parameter and max registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state != next_state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_row <= '0;
            num_ch  <= '0;
        end else if (state == LD_PARM) begin
            // read data lags the issued address by one cycle
            if (cnt == 3'd1) num_row <= param_intf.R_data[ROW_W-1:0];
            if (cnt == 3'd2) num_ch  <= param_intf.R_data[CH_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_q <= '0;
        end else if (state == RD && cnt != 3'd0) begin
            // first sample loads unconditionally so stale maxima never leak
            if (cnt == 3'd1 || $signed(sample) > $signed(max_q))
                max_q <= sample;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LD_PARM;
            LD_PARM: begin
                if (cnt == 3'd2) begin
                    if (pool_p == '0 || param_intf.R_data[CH_W-1:0] == '0)
                        next_state = FIN;
                    else
                        next_state = RD;
                end
            end
            RD:      if (cnt == 3'd4) next_state = WR;
            WR:      next_state = last_window ? FIN : RD;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign clr = (state == LD_PARM) && (cnt == 3'd2);
    assign adv = (state == WR);

    pool_addr_gen #(
        .ROW_W (ROW_W),
        .CH_W  (CH_W)
    ) u_addr_gen (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .adv         (adv),
        .num_row     (num_row),
        .num_ch      (num_ch),
        .rd_sel      (cnt[1:0]),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .last_window (last_window)
    );

    // ---------------------------------------------------------------
    // SRAM controls (decoded from registered state, so reset clears
    // them immediately)
    // ---------------------------------------------------------------
    always_comb begin
        param_intf.cs     = 1'b0;
        param_intf.oe     = 1'b1;
        param_intf.W_req  = WRITE_DIS;
        param_intf.W_data = '0;
        param_intf.addr   = ADDR_W'(PARM_ROW);
        if (state == LD_PARM && cnt < 3'd2) begin
            param_intf.cs   = 1'b1;
            param_intf.addr = (cnt == 3'd1) ? ADDR_W'(PARM_CH) : ADDR_W'(PARM_ROW);
        end
    end

    always_comb begin
        input_intf.cs     = 1'b0;
        input_intf.oe     = 1'b1;
        input_intf.W_req  = WRITE_DIS;
        input_intf.W_data = '0;
        input_intf.addr   = '0;
        if (state == RD && cnt < 3'd4) begin
            input_intf.cs   = 1'b1;
            input_intf.addr = rd_addr;
        end
    end

    always_comb begin
        output_intf.cs     = 1'b0;
        output_intf.oe     = 1'b1;
        output_intf.W_req  = WRITE_DIS;
        output_intf.W_data = '0;
        output_intf.addr   = '0;
        if (state == WR) begin
            output_intf.cs     = 1'b1;
            output_intf.W_req  = WRITE_ENB;
            output_intf.addr   = wr_addr;
            output_intf.W_data = {16'h0, {8{max_q[7]}}, max_q};
        end
    end

    assign finish = (state == FIN);

    // upper read-data bits and the pooled SRAM read port carry nothing here
    assign unused_rdata = ^{param_intf.R_data, input_intf.R_data, output_intf.R_data};

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 with SRAM models and a
// window-by-window reference model of the pooled output.
module tb_max_pool_2x2;
    import max_pool_2x2_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic finish;

    sp_ram_intf param_if ();
    sp_ram_intf input_if ();
    sp_ram_intf output_if ();

    max_pool_2x2 #(.ROW_W(6), .CH_W(9)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .finish      (finish),
        .param_intf  (param_if),
        .input_intf  (input_if),
        .output_intf (output_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int p_row = 0;
    int p_ch = 0;
    int stray = 0;

    logic [7:0] imem [0:4095];
    bit [31:0] wa_q[$];
    bit [31:0] wd_q[$];
    int        wc_q[$];
    int        ra_q[$];
    int        fin_q[$];
    bit [31:0] exp_a[$];
    bit [31:0] exp_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: registered address, data one cycle later
    always @(posedge clk) begin
        if (param_if.cs) param_if.R_data <= (param_if.addr == 0) ? 32'(p_row) : 32'(p_ch);
        if (input_if.cs) input_if.R_data <= {24'h0, imem[input_if.addr[11:0]]};
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (output_if.cs && output_if.W_req == WRITE_ENB) begin
            wa_q.push_back(output_if.addr);
            wd_q.push_back(output_if.W_data);
            wc_q.push_back(cyc);
        end
        if (output_if.W_req == WRITE_ENB && !output_if.cs) stray++;
        if (input_if.cs) ra_q.push_back(int'(input_if.addr));
        if (finish) fin_q.push_back(cyc);
    end

    function automatic int sv8(int a);
        logic signed [7:0] v;
        v = imem[a];
        return int'(v);
    endfunction

    // Reference: max of the four samples of each kept window, CHW order
    function automatic void model(int r, int ch);
        int p, m, v, b;
        p = r / 2;
        exp_a.delete();
        exp_d.delete();
        for (int c = 0; c < ch; c++)
            for (int oy = 0; oy < p; oy++)
                for (int ox = 0; ox < p; ox++) begin
                    b = c*r*r + 2*oy*r + 2*ox;
                    m = sv8(b);
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = sv8(b + dy*r + dx);
                            if (v > m) m = v;
                        end
                    exp_a.push_back(32'(c*p*p + oy*p + ox));
                    exp_d.push_back(32'(m) & 32'h0000_FFFF);
                end
    endfunction

    function automatic int total_cycles(int r, int ch);
        int p;
        p = r / 2;
        if (p == 0 || ch == 0) return 5;
        return 1 + 3 + 6*p*p*ch + 1;
    endfunction

    task automatic rand_mem();
        for (int i = 0; i < 4096; i++) imem[i] = 8'($urandom);
    endtask

    task automatic kick(input int r, input int ch, output int s);
        p_row = r;
        p_ch  = ch;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); fin_q.delete();
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fin(input int s, input int budget, output int fc);
        fc = -1;
        while (fin_q.size() == 0 && cyc < s + budget) @(posedge clk);
        if (fin_q.size() != 0) fc = fin_q[0];
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({finish, param_if.cs, input_if.cs, output_if.cs} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {finish, param_if.cs, input_if.cs, output_if.cs});
        end
        checks++;
        if ({param_if.addr, input_if.addr, output_if.addr, output_if.W_data} !== 128'h0) begin
            failures++; $display("FAIL reset_addr_data got=%h exp=0", {param_if.addr, input_if.addr, output_if.addr, output_if.W_data});
        end
        checks++;
        if (output_if.W_req !== WRITE_DIS) begin
            failures++; $display("FAIL reset_wreq got=%b exp=%b", output_if.W_req, WRITE_DIS);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({finish, param_if.cs, input_if.cs, output_if.cs, output_if.W_req} !== 5'b0) begin
            failures++; $display("FAIL idle_ctrl got=%b exp=00000", {finish, param_if.cs, input_if.cs, output_if.cs, output_if.W_req});
        end
    endtask

    task automatic test_r4_ramp();
        int s, fc;
        bit [31:0] exp_v [4];
        exp_v = '{32'd5, 32'd7, 32'd13, 32'd15};
        for (int i = 0; i < 16; i++) imem[i] = 8'(i);
        kick(4, 1, s);
        wait_fin(s, 60, fc);
        checks++;
        if (wa_q.size() != 4) begin
            failures++; $display("FAIL r4_count got=%0d exp=4", wa_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== 32'(i) || wd_q[i] !== exp_v[i] || wc_q[i] !== s + 9 + 6*i) begin
                failures++;
                $display("FAIL r4_write%0d got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                         i, wa_q[i], wd_q[i], wc_q[i] - s, i, exp_v[i], 9 + 6*i);
            end
        end
        checks++;
        if (fc !== s + 28) begin
            failures++; $display("FAIL r4_finish got=%0d exp=%0d", fc - s, 28);
        end
    endtask

    task automatic test_odd_r5();
        int s, fc, rem, bad;
        rand_mem();
        model(5, 2);
        kick(5, 2, s);
        wait_fin(s, total_cycles(5, 2) + 20, fc);
        checks++;
        if (wa_q.size() != 8 || exp_a.size() != 8) begin
            failures++; $display("FAIL r5_count got=%0d exp=8", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                failures++; $display("FAIL r5_write%0d got a=%0d d=%h exp a=%0d d=%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
            end
        end
        bad = 0;
        foreach (ra_q[i]) begin
            rem = ra_q[i] % 25;
            if (ra_q[i] >= 50 || rem / 5 == 4 || rem % 5 == 4) bad++;
        end
        checks++;
        if (bad != 0 || ra_q.size() != 32) begin
            failures++; $display("FAIL r5_reads bad=%0d count=%0d exp bad=0 count=32", bad, ra_q.size());
        end
        checks++;
        if (fc !== s + total_cycles(5, 2) - 1) begin
            failures++; $display("FAIL r5_finish got=%0d exp=%0d", fc - s, total_cycles(5, 2) - 1);
        end
    endtask

    task automatic test_signed();
        int s, fc;
        rand_mem();
        imem[0] = 8'h80; imem[1] = 8'hFF; imem[4] = 8'h81; imem[5] = 8'hFE;
        imem[2] = 8'h80; imem[3] = 8'h80; imem[6] = 8'h80; imem[7] = 8'h80;
        kick(4, 1, s);
        wait_fin(s, 60, fc);
        checks++;
        if (wa_q.size() < 2 || wd_q[0] !== 32'h0000_FFFF) begin
            failures++; $display("FAIL signed_neg1 got=%h exp=0000ffff", (wd_q.size() > 0) ? wd_q[0] : 32'hx);
        end
        checks++;
        if (wa_q.size() < 2 || wd_q[1] !== 32'h0000_FF80) begin
            failures++; $display("FAIL signed_min got=%h exp=0000ff80", (wd_q.size() > 1) ? wd_q[1] : 32'hx);
        end
    endtask

    task automatic test_degenerate();
        int s, fc;
        kick(1, 8, s);
        wait_fin(s, 30, fc);
        checks++;
        if (wa_q.size() != 0 || ra_q.size() != 0 || fc !== s + 4) begin
            failures++; $display("FAIL r1_empty writes=%0d reads=%0d fin=%0d exp 0 0 4", wa_q.size(), ra_q.size(), fc - s);
        end
        @(negedge clk);
        kick(6, 0, s);
        wait_fin(s, 30, fc);
        checks++;
        if (wa_q.size() != 0 || ra_q.size() != 0 || fc !== s + 4) begin
            failures++; $display("FAIL ch0_empty writes=%0d reads=%0d fin=%0d exp 0 0 4", wa_q.size(), ra_q.size(), fc - s);
        end
    endtask

    task automatic test_reset_mid();
        int s, fc, nw;
        rand_mem();
        model(4, 2);
        kick(4, 2, s);
        while (cyc < s + 18) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({finish, param_if.cs, input_if.cs, output_if.cs, output_if.W_req} !== 5'b0 ||
            {input_if.addr, output_if.addr, output_if.W_data} !== 96'h0) begin
            failures++;
            $display("FAIL midrst_outputs got ctrl=%b ia=%0d oa=%0d wd=%h exp all 0",
                     {finish, param_if.cs, input_if.cs, output_if.cs, output_if.W_req},
                     input_if.addr, output_if.addr, output_if.W_data);
        end
        nw = wa_q.size();
        repeat (3) @(negedge clk);
        checks++;
        if (nw != 2 || wa_q.size() != 2) begin
            failures++; $display("FAIL midrst_writes got=%0d/%0d exp=2", nw, wa_q.size());
        end
        rstn = 1'b1;
        @(negedge clk);
        kick(4, 2, s);
        wait_fin(s, total_cycles(4, 2) + 20, fc);
        checks++;
        if (wa_q.size() != exp_a.size()) begin
            failures++; $display("FAIL midrst_rerun_count got=%0d exp=%0d", wa_q.size(), exp_a.size());
        end
        for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i] || wc_q[i] !== s + 9 + 6*i) begin
                failures++; $display("FAIL midrst_rerun%0d got a=%0d d=%h exp a=%0d d=%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s, s2, fc, fc2;
        bit [31:0] a1[$];
        bit [31:0] d1[$];
        int        c1[$];
        rand_mem();
        model(4, 1);
        kick(4, 1, s);
        while (cyc < s + 6) @(negedge clk);
        start = 1'b1;              // lands in RD, must be ignored
        @(negedge clk);
        start = 1'b0;
        wait_fin(s, 60, fc);
        checks++;
        if (fc !== s + 28 || wa_q.size() != exp_a.size()) begin
            failures++; $display("FAIL ignore_start fin=%0d writes=%0d exp fin=28 writes=%0d", fc - s, wa_q.size(), exp_a.size());
        end
        for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                failures++; $display("FAIL ignore_write%0d got a=%0d d=%h exp a=%0d d=%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
            end
        end
        a1 = wa_q; d1 = wd_q;
        foreach (wc_q[i]) c1.push_back(wc_q[i] - s);
        kick(4, 1, s2);            // cycle right after FIN
        wait_fin(s2, 60, fc2);
        checks++;
        if (fc2 !== s2 + 28 || wa_q.size() != a1.size()) begin
            failures++; $display("FAIL rerun_shape fin=%0d writes=%0d exp fin=28 writes=%0d", fc2 - s2, wa_q.size(), a1.size());
        end
        for (int i = 0; i < wa_q.size() && i < a1.size(); i++) begin
            checks++;
            if (wa_q[i] !== a1[i] || wd_q[i] !== d1[i] || wc_q[i] - s2 !== c1[i]) begin
                failures++; $display("FAIL rerun_write%0d got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                                     i, wa_q[i], wd_q[i], wc_q[i] - s2, a1[i], d1[i], c1[i]);
            end
        end
    endtask

    task automatic test_random();
        int s, fc, r, ch, err;
        for (int k = 0; k < 5; k++) begin
            r  = $urandom_range(2, 9);
            ch = $urandom_range(1, 3);
            rand_mem();
            model(r, ch);
            kick(r, ch, s);
            wait_fin(s, total_cycles(r, ch) + 20, fc);
            checks++;
            if (fc !== s + total_cycles(r, ch) - 1 || wa_q.size() != exp_a.size()) begin
                failures++; $display("FAIL rand%0d_shape r=%0d ch=%0d fin=%0d writes=%0d exp fin=%0d writes=%0d",
                                     k, r, ch, fc - s, wa_q.size(), total_cycles(r, ch) - 1, exp_a.size());
            end
            err = 0;
            for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++)
                if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i] || wc_q[i] !== s + 9 + 6*i) err++;
            checks++;
            if (err != 0) begin
                failures++; $display("FAIL rand%0d_data r=%0d ch=%0d bad_writes=%0d exp=0", k, r, ch, err);
            end
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL wreq_outside_wr got=%0d exp=0", stray);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_r4_ramp();
        test_odd_r5();
        test_signed();
        test_degenerate();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Stride-2, 2x2 max-pooling stage that sits directly downstream of the 1x1 convolution engine. Once the conv engine raises `finish`, this block reads the conv output SRAM (CHW layout, one 8-bit activation per word). It writes one pooled activation per 2x2 window into a pooled-output SRAM, in the same CHW layout. Feature-map geometry comes from the shared parameter SRAM.

## Interface
Parameters:
- `ROW_W`, default 6: width of the `num_row` register.
- `CH_W`, default 9: width of the `num_CH` register.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle start pulse; sampled only in IDLE.
- `finish`, output, 1: one-cycle done pulse.
- `param_intf`, sp_ram_intf.compute, –: parameter SRAM. Word 0 holds `num_row` (input height = width). Word 1 holds `num_CH`.
- `input_intf`, sp_ram_intf.compute, –: conv output SRAM, read only. Activation is `R_data[7:0]`, signed.
- `output_intf`, sp_ram_intf.compute, –: pooled SRAM, write only. `W_data = {16'h0, sext16(max)}`.

## Operation
- All SRAMs are single-port with registered `addr`. Read data is valid on `R_data` one cycle after the cycle in which `cs`=1 and `addr` were presented.
- On `param_intf`, `input_intf` and `output_intf`, `oe` is tied to 1. Other write controls are tied as follows:
  - `W_req` tied to `WRITE_DIS` on `param_intf` and `input_intf`.
  - `W_data` tied to 0 on `param_intf` and `input_intf`.
- Derived quantities:
  - `R` = `num_row`; `P` = `R>>1` (floor). For odd `R`, the last row and last column are dropped.
  - Input address: `c*R*R + y*R + x`.
  - Output address: `c*P*P + oy*P + ox`. Outputs are written strictly sequentially from 0.
- Window base address: `c*R*R + 2*oy*R + 2*ox`. The four reads go to base+0, base+1, base+R and base+R+1, in that order.
- Max rule:
  - The running max is an 8-bit signed value.
  - The first sample of each window loads the max unconditionally. Each later sample replaces it only if strictly greater (signed compare).
- Loop order: `ox` is innermost, then `oy`, then `c`.
- States:
  - IDLE: all `cs`=0. Move to LD_PARM when `start`=1.
  - LD_PARM (3 cycles): cnt0 issues addr 0; cnt1 issues addr 1 and captures `num_row`; cnt2 captures `num_CH`. Then:
    - if `P==0` or `num_CH==0`, go to FIN;
    - otherwise clear counters and go to RD.
  - RD (5 cycles, cnt 0..4):
    - `input_intf.cs`=1 on cnt0..3, with addresses base+0/+1/+R/+R+1.
    - Samples are captured into the running max on cnt1..4.
    - Go to WR.
  - WR (1 cycle):
    - `output_intf.cs`=1 and `W_req`=`WRITE_ENB`, with the current output address and the max.
    - Advance `ox`/`oy`/`c` and the output address.
    - If the last window of the last channel was just written, go to FIN; otherwise go to RD.
  - FIN (1 cycle): `finish`=1, then IDLE.
- `start` is ignored outside IDLE.
- Parameters are re-read on every `start`. Counters and addresses restart at 0.

## Timing
- Reset values:
  - `finish`=0.
  - All `cs`=0 and all `addr`=0.
  - `output_intf.W_req`=`WRITE_DIS` and `output_intf.W_data`=0.
  - FSM in IDLE; all counters, `num_row`, `num_CH` and the max register are 0.
- Latency:
  - From `start` to the first write: 1 (IDLE) + 3 (LD_PARM) + 5 (RD) cycles. The write occurs in cycle 10 after the `start` edge.
  - Throughput is 6 cycles per pooled output.
  - Total time is 1 + 3 + 6·P·P·num_CH + 1 cycles.
- `W_req` is asserted for exactly one cycle per output and never outside WR.
- Reset mid-operation returns everything to its reset values immediately. No partial write completes after reset asserts.
- Widths:
  - Address products are computed at 32 bits.
  - `R*R` fits in 12 bits.
  - The full input size (≤63·63·511) fits in 21 bits.

## Structure
- The shared package (`ConvAcc` header/package) holds:
  - `WRITE_ENB` / `WRITE_DIS`;
  - the state enum `pool_state_t` {IDLE, LD_PARM, RD, WR, FIN};
  - parameter-word offsets `PARM_ROW=0`, `PARM_CH=1`.
- One sub-module, `pool_addr_gen`:
  - holds the `ox`/`oy`/`c` counters, the window base, the read-offset select and the output address;
  - reports a `last_window` flag.
- The top level holds the FSM, the parameter registers and the max register.

## Test plan
- R=4, CH=1, input 0..15 row-major → writes to addr 0..3 of 5, 7, 13, 15; then `finish` at cycle 1+3+24+1.
- R=5, CH=2 → P=2; exactly 8 writes; row 4 and column 4 of each channel are never read (checked via input `cs`/`addr`).
- Window {0x80, 0xFF, 0x81, 0xFE} → W_data = 0x0000_FFFF (−1); window of all 0x80 → 0x0000_FF80.
- R=1, CH=8 → no input reads and no writes; `finish` 5 cycles after `start`.
- `rstn` asserted during the RD of the 3rd window → all outputs at reset values; a subsequent `start` restarts from output addr 0 with correct results.
- `start` pulsed while in RD → ignored; a second `start` in the cycle after FIN → full rerun producing identical writes.
